// File: rtl/bus_switch_if.sv
// Channel-select bus between a controller and the break-before-make bus switch.
interface bus_switch_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in;
    logic [SW-1:0]             sel;
    logic                      enable;
    logic [WIDTH-1:0]          out;
    logic                      active;
    logic [SW-1:0]             cur_sel;
    logic                      busy;

    modport master (
        output in, sel, enable,
        input  out, active, cur_sel, busy
    );

    modport slave (
        input  in, sel, enable,
        output out, active, cur_sel, busy
    );
endinterface

// File: rtl/bus_switch.sv
// Break-before-make channel switch: registered mux output with a forced-zero
// dead time whenever the connected channel changes.
//
// state    | meaning
// ST_OFF   | nothing connected, out held at 0
// ST_CONN  | cur_sel connected, out follows its channel one clock late
// ST_BREAK | dead time between channels, out held at 0
module bus_switch #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_switch_if.slave bus
);
    localparam int             SW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SW:0]    CH_LIMIT  = CHANNELS[SW:0];
    localparam logic [3:0]     DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_CONN  = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SW-1:0]     cur_q, cur_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [WIDTH-1:0]  ch_data;
    logic              sel_valid;

    assign sel_valid = ({1'b0, bus.sel} < CH_LIMIT);

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_q == SW'(k)) begin
                ch_data = bus.in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            cur_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        out_d   = '0;
        case (state_q)
            ST_OFF: begin
                if (bus.enable && sel_valid) begin
                    cur_d   = bus.sel;
                    state_d = ST_CONN;
                end
            end
            ST_CONN: begin
                if (!bus.enable) begin
                    state_d = ST_OFF;
                end else if (bus.sel != cur_q) begin
                    state_d = ST_BREAK;
                    cnt_d   = DEAD_LOAD;
                end else begin
                    out_d = ch_data;
                end
            end
            ST_BREAK: begin
                // sel is only looked at on the final dead-time edge
                if (!bus.enable) begin
                    state_d = ST_OFF;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (sel_valid) begin
                    cur_d   = bus.sel;
                    state_d = ST_CONN;
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign bus.out     = out_q;
    assign bus.active  = (state_q == ST_CONN);
    assign bus.busy    = (state_q == ST_BREAK);
    assign bus.cur_sel = cur_q;
endmodule

// File: tb/tb_bus_switch.sv
// Scoreboard bench for bus_switch: a 4-channel and a 3-channel instance.
module tb_bus_switch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    typedef struct {
        logic [7:0] o;
        logic       a;
        logic       b;
        logic [1:0] c;
    } exp_t;

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [31:0] in;
        logic [7:0]  o;
        logic        a;
        logic        b;
        logic [1:0]  c;
    } row_t;

    exp_t exp_q[$];

    bus_switch_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();
    bus_switch_if #(.WIDTH(8), .CHANNELS(3)) bus1 ();

    bus_switch #(.WIDTH(8), .CHANNELS(4), .DEAD_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    bus_switch #(.WIDTH(8), .CHANNELS(3), .DEAD_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.enable = 1'b0;
        bus1.enable = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        bus0.in = 32'hdeadbeef; bus0.sel = 2'd1; bus0.enable = 1'b1;
        bus1.in = 24'h123456;   bus1.sel = 2'd1; bus1.enable = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t'{8'h00, 1'b0, 1'b0, 2'd0});
            if (i == 0) #1; else tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL reset step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
        do_reset();
    endtask

    task automatic test_basic_connect();
        row_t rows[3];
        exp_t e;
        rows = '{
            '{1'b1, 2'd1, 32'h00007f00, 8'h00, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd1, 32'h00007f00, 8'h7f, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd1, 32'h00007f00, 8'h7f, 1'b1, 1'b0, 2'd1}};
        do_reset();
        foreach (rows[i]) begin
            bus0.enable = rows[i].en; bus0.sel = rows[i].sel; bus0.in = rows[i].in;
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL basic_connect step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    task automatic test_channel_change();
        row_t rows[6];
        exp_t e;
        rows = '{
            '{1'b1, 2'd0, 32'h00ff0001, 8'h00, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd0, 32'h00ff0001, 8'h01, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b1, 2'd0},
            '{1'b1, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b1, 2'd0},
            '{1'b1, 2'd2, 32'h00ff0001, 8'h00, 1'b1, 1'b0, 2'd2},
            '{1'b1, 2'd2, 32'h00ff0001, 8'hff, 1'b1, 1'b0, 2'd2}};
        do_reset();
        foreach (rows[i]) begin
            bus0.enable = rows[i].en; bus0.sel = rows[i].sel; bus0.in = rows[i].in;
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL channel_change step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    task automatic test_break_resample();
        row_t rows[6];
        exp_t e;
        rows = '{
            '{1'b1, 2'd0, 32'h5a000001, 8'h00, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd0, 32'h5a000001, 8'h01, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd2, 32'h5a000001, 8'h00, 1'b0, 1'b1, 2'd0},
            '{1'b1, 2'd1, 32'h5a000001, 8'h00, 1'b0, 1'b1, 2'd0},
            '{1'b1, 2'd3, 32'h5a000001, 8'h00, 1'b1, 1'b0, 2'd3},
            '{1'b1, 2'd3, 32'h5a000001, 8'h5a, 1'b1, 1'b0, 2'd3}};
        do_reset();
        foreach (rows[i]) begin
            bus0.enable = rows[i].en; bus0.sel = rows[i].sel; bus0.in = rows[i].in;
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL break_resample step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    task automatic test_break_disable();
        row_t rows[6];
        exp_t e;
        rows = '{
            '{1'b1, 2'd0, 32'h00ff0001, 8'h00, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd0, 32'h00ff0001, 8'h01, 1'b1, 1'b0, 2'd0},
            '{1'b1, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b1, 2'd0},
            '{1'b0, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b0, 2'd0},
            '{1'b0, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b0, 2'd0},
            '{1'b0, 2'd2, 32'h00ff0001, 8'h00, 1'b0, 1'b0, 2'd0}};
        do_reset();
        foreach (rows[i]) begin
            bus0.enable = rows[i].en; bus0.sel = rows[i].sel; bus0.in = rows[i].in;
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL break_disable step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    task automatic test_invalid_sel();
        row_t rows[9];
        exp_t e;
        rows = '{
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b0, 2'd0},
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b0, 2'd0},
            '{1'b1, 2'd1, 32'h00332211, 8'h00, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd1, 32'h00332211, 8'h22, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b1, 2'd1},
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b1, 2'd1},
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b0, 2'd1},
            '{1'b1, 2'd3, 32'h00332211, 8'h00, 1'b0, 1'b0, 2'd1},
            '{1'b1, 2'd2, 32'h00332211, 8'h00, 1'b1, 1'b0, 2'd2}};
        do_reset();
        foreach (rows[i]) begin
            bus1.enable = rows[i].en; bus1.sel = rows[i].sel; bus1.in = rows[i].in[23:0];
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus1.out, bus1.active, bus1.busy, bus1.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL invalid_sel step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus1.out, bus1.active, bus1.busy, bus1.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
        bus1.enable = 1'b0;
    endtask

    task automatic test_async_reset();
        row_t pre[2];
        row_t post[3];
        exp_t e;
        pre = '{
            '{1'b1, 2'd1, 32'h00008000, 8'h00, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd1, 32'h00008000, 8'h80, 1'b1, 1'b0, 2'd1}};
        post = '{
            '{1'b0, 2'd1, 32'h00004400, 8'h00, 1'b0, 1'b0, 2'd0},
            '{1'b1, 2'd1, 32'h00004400, 8'h00, 1'b1, 1'b0, 2'd1},
            '{1'b1, 2'd1, 32'h00004400, 8'h44, 1'b1, 1'b0, 2'd1}};
        do_reset();
        foreach (pre[i]) begin
            bus0.enable = pre[i].en; bus0.sel = pre[i].sel; bus0.in = pre[i].in;
            exp_q.push_back(exp_t'{pre[i].o, pre[i].a, pre[i].b, pre[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL async_reset_pre step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
        // assert between edges; outputs must clear without a clock
        #2;
        rst_n = 1'b0;
        exp_q.push_back(exp_t'{8'h00, 1'b0, 1'b0, 2'd0});
        #1;
        e = exp_q.pop_front();
        total++;
        if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
            $display("FAIL async_reset_mid: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                     bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
        else passed++;
        #2;
        rst_n = 1'b1;
        foreach (post[i]) begin
            bus0.enable = post[i].en; bus0.sel = post[i].sel; bus0.in = post[i].in;
            exp_q.push_back(exp_t'{post[i].o, post[i].a, post[i].b, post[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL async_reset_post step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    task automatic test_data_tracking();
        row_t rows[5];
        exp_t e;
        rows = '{
            '{1'b1, 2'd3, 32'h000f0e0d, 8'h00, 1'b1, 1'b0, 2'd3},
            '{1'b1, 2'd3, 32'h000f0e0d, 8'h00, 1'b1, 1'b0, 2'd3},
            '{1'b1, 2'd3, 32'h200f0e0d, 8'h20, 1'b1, 1'b0, 2'd3},
            '{1'b1, 2'd3, 32'h800f0e0d, 8'h80, 1'b1, 1'b0, 2'd3},
            '{1'b1, 2'd3, 32'h800f0e0d, 8'h80, 1'b1, 1'b0, 2'd3}};
        do_reset();
        foreach (rows[i]) begin
            bus0.enable = rows[i].en; bus0.sel = rows[i].sel; bus0.in = rows[i].in;
            exp_q.push_back(exp_t'{rows[i].o, rows[i].a, rows[i].b, rows[i].c});
            tick();
            e = exp_q.pop_front();
            total++;
            if ({bus0.out, bus0.active, bus0.busy, bus0.cur_sel} !== {e.o, e.a, e.b, e.c})
                $display("FAIL data_tracking step %0d: got out=%h act=%b busy=%b cur=%0d, want out=%h act=%b busy=%b cur=%0d",
                         i, bus0.out, bus0.active, bus0.busy, bus0.cur_sel, e.o, e.a, e.b, e.c);
            else passed++;
        end
    endtask

    initial begin
        bus0.in = '0; bus0.sel = '0; bus0.enable = 1'b0;
        bus1.in = '0; bus1.sel = '0; bus1.enable = 1'b0;
        test_reset();
        test_basic_connect();
        test_channel_change();
        test_break_resample();
        test_break_disable();
        test_invalid_sel();
        test_async_reset();
        test_data_tracking();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
